// File: rtl/lock_pkg.sv
// Shared definitions for the keypad front end and the lock core.
package lock_pkg;

  localparam int unsigned KEY_W   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned MATRIX_N = 4;

  // Key codes follow code = row*4 + col on the keypad matrix.
  localparam logic [KEY_W-1:0] KEY_0    = 4'h0;
  localparam logic [KEY_W-1:0] KEY_1    = 4'h1;
  localparam logic [KEY_W-1:0] KEY_2    = 4'h2;
  localparam logic [KEY_W-1:0] KEY_3    = 4'h3;
  localparam logic [KEY_W-1:0] KEY_4    = 4'h4;
  localparam logic [KEY_W-1:0] KEY_5    = 4'h5;
  localparam logic [KEY_W-1:0] KEY_6    = 4'h6;
  localparam logic [KEY_W-1:0] KEY_7    = 4'h7;
  localparam logic [KEY_W-1:0] KEY_8    = 4'h8;
  localparam logic [KEY_W-1:0] KEY_9    = 4'h9;
  localparam logic [KEY_W-1:0] KEY_STAR = 4'hE;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'hF;

  // Scanner state encoding, also observed by the lock FSM for debug.
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } scan_state_e;

  // Key code from latched row and column indices.
  function automatic logic [KEY_W-1:0] encode_key(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return {row, col};
  endfunction

  // Index of the lowest-numbered row reading low (active-low rows).
  function automatic logic [IDX_W-1:0] lowest_low_row(input logic [MATRIX_N-1:0] rows_n);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MATRIX_N - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous keypad rows; resets to idle-high.
module keypad_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values: shift the input through two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, released high so an idle keypad reads no press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row debounce, one-shot key delivery over valid/ready.
module keypad_scanner
  import lock_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready
);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  scan_state_e       state_q, state_d;
  logic [IDX_W-1:0]  col_idx_q, col_idx_d;
  logic [IDX_W-1:0]  row_idx_q, row_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        col_n_q, col_n_d;
  logic [KEY_W-1:0]  key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        rows_s;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rows_s)
  );

  // Next-state and output logic; the counter clears on every state change.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    col_n_d     = 4'b1111;

    if (!ena) begin
      state_d     = SCAN;
      col_idx_d   = '0;
      cnt_d       = '0;
      key_valid_d = 1'b0;
    end else begin
      col_n_d = ~(4'b0001 << col_idx_q);
      case (state_q)
        SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            if (rows_s != 4'hF) begin
              row_idx_d = lowest_low_row(rows_s);
              state_d   = DEBOUNCE;
            end else begin
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (rows_s[row_idx_q]) begin
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
            cnt_d     = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d     = EMIT;
            cnt_d       = '0;
            key_code_d  = encode_key(row_idx_q, col_idx_q);
            key_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EMIT: begin
          if (key_ready) begin
            state_d     = WAIT_REL;
            cnt_d       = '0;
            key_valid_d = 1'b0;
          end
        end
        WAIT_REL: begin
          if (rows_s != 4'hF) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d   = SCAN;
            col_idx_d = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      col_n_q     <= 4'b1111;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  logic [3:0] key_mat [4];
  int passed = 0;
  int total  = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  // Pressed key connects its row to its column; driven-low column pulls the row low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(key_mat[r] & ~col_n);
  end

  // Count completed handshakes.
  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) key_mat[r] = 4'h0;
  endtask

  task automatic wait_valid(input int budget, input string name, output int lat);
    lat = 0;
    while (key_valid !== 1'b1 && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (key_valid !== 1'b1) check({name, "_valid_timeout"}, key_valid, 1);
  endtask

  // Release while in WAIT_REL with the counter parked; latched column holds 10 cycles, then col 0.
  task automatic release_and_resume(input int col, input string name);
    logic [3:0] e;
    e = ~(4'b0001 << col);
    clear_keys();
    step(10);
    check({name, "_hold_col"}, col_n, e);
    step(1);
    check({name, "_resume_col0"}, col_n, 4'b1110);
  endtask

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
    int         hold;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat;
    int hs0;
    int vcnt;
    int bad;
    logic [3:0] e;

    vecs[0] = '{row: 2, col: 1, code: 4'h9, hold: 200};
    vecs[1] = '{row: 0, col: 0, code: 4'h0, hold: 20};
    vecs[2] = '{row: 3, col: 3, code: 4'hF, hold: 20};
    vecs[3] = '{row: 1, col: 2, code: 4'h6, hold: 20};
    vecs[4] = '{row: 3, col: 0, code: 4'hC, hold: 20};
    vecs[5] = '{row: 0, col: 3, code: 4'h3, hold: 20};

    rst_n     = 1'b0;
    ena       = 1'b1;
    key_ready = 1'b1;
    clear_keys();

    // Reset values.
    step(2);
    check("rst_col_n", col_n, 4'b1111);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    rst_n = 1'b1;
    step(10);

    // Asynchronous reset mid-scan takes effect before the next clock edge.
    #2 rst_n = 1'b0;
    #1 check("async_rst_col_n", col_n, 4'b1111);
    step(3);
    rst_n = 1'b1;

    // Idle scan: each column active-low for 4 cycles, starting with column 0.
    vcnt = 0;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      e = ~(4'b0001 << (((k - 1) / 4) % 4));
      check($sformatf("idle_col_k%0d", k), col_n, e);
      if (key_valid) vcnt++;
    end
    check("idle_no_valid", vcnt, 0);

    // Single presses with the consumer ready.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm  = $sformatf("press%0d", i);
      hs0 = hs_cnt;
      key_mat[vecs[i].row][vecs[i].col] = 1'b1;
      wait_valid(60, nm, lat);
      check({nm, "_latency_le27"}, lat <= 27, 1);
      check({nm, "_code"}, key_code, vecs[i].code);
      step(1);
      check({nm, "_pulse_1cyc"}, key_valid, 0);
      step(vecs[i].hold);
      check({nm, "_one_event"}, hs_cnt - hs0, 1);
      release_and_resume(vecs[i].col, nm);
    end

    // Two keys in column 3 with the scan entering at column 0: lowest row wins.
    hs0 = hs_cnt;
    key_mat[0][3] = 1'b1;
    key_mat[3][3] = 1'b1;
    wait_valid(60, "two_keys", lat);
    check("two_keys_code", key_code, 4'h3);
    step(5);
    key_mat[2][0] = 1'b1;
    step(60);
    check("two_keys_extra_ignored", hs_cnt - hs0, 1);
    check("two_keys_valid_low", key_valid, 0);
    release_and_resume(3, "two_keys");

    // Keys in columns 1 and 2: first column reached wins even with a lower row elsewhere.
    key_mat[2][1] = 1'b1;
    key_mat[0][2] = 1'b1;
    wait_valid(60, "first_col", lat);
    check("first_col_code", key_code, 4'h9);
    step(3);
    release_and_resume(1, "first_col");

    // Bounce: 3-cycle toggles never satisfy the debounce window.
    hs0  = hs_cnt;
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      key_mat[1][2] = (((i / 3) % 2) == 0) ? 1'b1 : 1'b0;
      step(1);
      if (key_valid) vcnt++;
    end
    check("bounce_no_valid", vcnt, 0);
    key_mat[1][2] = 1'b1;
    wait_valid(60, "bounce", lat);
    check("bounce_code", key_code, 4'h6);
    step(3);
    check("bounce_one_event", hs_cnt - hs0, 1);
    release_and_resume(2, "bounce");

    // Backpressure: valid and code hold until ready; release meanwhile is not counted.
    key_ready = 1'b0;
    hs0 = hs_cnt;
    key_mat[0][1] = 1'b1;
    wait_valid(60, "bp", lat);
    check("bp_code", key_code, 4'h1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (key_valid !== 1'b1 || key_code !== 4'h1) bad++;
      if (i == 5) clear_keys();
      step(1);
    end
    check("bp_stable_20", bad, 0);
    check("bp_no_transfer", hs_cnt - hs0, 0);
    key_ready = 1'b1;
    check("bp_valid_at_ready", key_valid, 1);
    step(1);
    check("bp_valid_dropped", key_valid, 0);
    check("bp_one_transfer", hs_cnt - hs0, 1);
    step(8);
    check("bp_wait_rel_col", col_n, 4'b1101);
    step(1);
    check("bp_resume_col0", col_n, 4'b1110);

    // Disable during EMIT drops the key; re-enable redetects the held key.
    key_ready = 1'b0;
    hs0 = hs_cnt;
    key_mat[3][2] = 1'b1;
    wait_valid(60, "dis", lat);
    check("dis_code", key_code, 4'hE);
    ena = 1'b0;
    step(1);
    check("dis_valid_low", key_valid, 0);
    check("dis_col_idle", col_n, 4'b1111);
    step(5);
    check("dis_col_still_idle", col_n, 4'b1111);
    check("dis_no_transfer", hs_cnt - hs0, 0);
    ena = 1'b1;
    key_ready = 1'b1;
    wait_valid(80, "reen", lat);
    check("reen_code", key_code, 4'hE);
    step(1);
    check("reen_one_transfer", hs_cnt - hs0, 1);
    release_and_resume(2, "reen");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
